// File: rtl/pcie_trans_mvc.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module  : pcie_trans_mvc                                                    |
// | Purpose : main FIFO -> NUM_VC VC FIFOs -> two destination output registers  |
// |           with control FSM and programmable pause thresholds.               |
// |           Define ARB_RR_EN for a round-robin arbiter (default: VC0 first).  |
// | Revision: 1.0 - initial parametrised release                                |
// +-----------------------------------------------------------------------------+
module pcie_trans_mvc #(
  parameter int DATA_W    = 6,
  parameter int NUM_VC    = 2,
  parameter int MF_DEPTH  = 4,
  parameter int VC_DEPTH  = 16,
  parameter int MF_TH_DEF = 3,
  parameter int VC_TH_DEF = 12
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        init,
  input  logic [$clog2(MF_DEPTH):0]   umbral_mf,
  input  logic [$clog2(VC_DEPTH):0]   umbral_vc,
  input  logic                        push,
  input  logic [DATA_W-1:0]           data_in,
  input  logic                        ready_0,
  input  logic                        ready_1,
  output logic [DATA_W-1:0]           data_out0,
  output logic [DATA_W-1:0]           data_out1,
  output logic                        valid_0,
  output logic                        valid_1,
  output logic                        pausa_mf,
  output logic [NUM_VC-1:0]           pausa_vc,
  output logic                        active_out,
  output logic                        idle_out,
  output logic                        error_out,
  output logic [NUM_VC:0]             error_id
);

  localparam int VCW  = $clog2(NUM_VC);
  localparam int MFAW = $clog2(MF_DEPTH);
  localparam int VCAW = $clog2(VC_DEPTH);
  localparam logic [MFAW:0] MF_FULL = (MFAW+1)'(MF_DEPTH);
  localparam logic [VCAW:0] VC_FULL = (VCAW+1)'(VC_DEPTH);

  localparam logic [2:0] S_RESET  = 3'd0;
  localparam logic [2:0] S_INIT   = 3'd1;
  localparam logic [2:0] S_IDLE   = 3'd2;
  localparam logic [2:0] S_ACTIVE = 3'd3;
  localparam logic [2:0] S_ERROR  = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [MFAW:0]     th_mf_q, th_mf_d;
  logic [VCAW:0]     th_vc_q, th_vc_d;
  logic [DATA_W-1:0] mf_mem_q [MF_DEPTH];
  logic [MFAW-1:0]   mf_wr_q, mf_wr_d, mf_rd_q, mf_rd_d;
  logic [MFAW:0]     mf_count_q, mf_count_d;
  logic [DATA_W-1:0] vc_mem_q [NUM_VC][VC_DEPTH];
  logic [VCAW-1:0]   vc_wr_q [NUM_VC];
  logic [VCAW-1:0]   vc_wr_d [NUM_VC];
  logic [VCAW-1:0]   vc_rd_q [NUM_VC];
  logic [VCAW-1:0]   vc_rd_d [NUM_VC];
  logic [VCAW:0]     vc_count_q [NUM_VC];
  logic [VCAW:0]     vc_count_d [NUM_VC];
  logic [DATA_W-1:0] out_q [2];
  logic [DATA_W-1:0] out_d [2];
  logic [1:0]        valid_q, valid_d;
  logic [NUM_VC:0]   error_id_q, error_id_d;
`ifdef ARB_RR_EN
  logic [VCW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [VCW-1:0]    rr_idx;
`endif

  logic              run, mf_full, mf_pop, mf_push_ok, mf_err, any_busy;
  logic [DATA_W-1:0] mf_head;
  logic [VCW-1:0]    head_vc;
  logic [NUM_VC-1:0] vc_pause, vc_elig, vc_hit, vc_pop, vc_wr, vc_err, vc_dest;
  logic [DATA_W-1:0] vc_head [NUM_VC];
  logic [1:0]        rdy, dst_free;
  logic              gnt_valid, gnt_dest;
  logic [VCW-1:0]    gnt_vc;

  // Dispatch: the MF head moves to its VC unless that VC is paused (no bypass)
  always_comb begin
    run = (state_q == S_IDLE) || (state_q == S_ACTIVE);
    for (int k = 0; k < NUM_VC; k++) vc_pause[k] = vc_count_q[k] >= th_vc_q;
    mf_full    = mf_count_q == MF_FULL;
    mf_head    = mf_mem_q[mf_rd_q];
    head_vc    = mf_head[DATA_W-1 -: VCW];
    mf_pop     = run && (mf_count_q != '0) && !vc_pause[head_vc];
    mf_push_ok = run && push && (!mf_full || mf_pop);
    mf_err     = run && push && mf_full && !mf_pop;
  end

  always_comb begin
    rdy      = {ready_1, ready_0};
    dst_free = ~valid_q | rdy;
    for (int k = 0; k < NUM_VC; k++) begin
      vc_head[k] = vc_mem_q[k][vc_rd_q[k]];
      vc_dest[k] = vc_head[k][DATA_W-1-VCW];
      vc_elig[k] = run && (vc_count_q[k] != '0) && dst_free[vc_dest[k]];
    end
    gnt_valid = 1'b0;
    gnt_vc    = '0;
`ifdef ARB_RR_EN
    rr_idx = '0;
    // Descending walk so the candidate closest to the pointer is written last
    for (int i = NUM_VC-1; i >= 0; i--) begin
      rr_idx = rr_ptr_q + VCW'(i);
      if (vc_elig[rr_idx]) begin
        gnt_valid = 1'b1;
        gnt_vc    = rr_idx;
      end
    end
`else
    for (int k = NUM_VC-1; k >= 0; k--) begin
      if (vc_elig[k]) begin
        gnt_valid = 1'b1;
        gnt_vc    = VCW'(k);
      end
    end
`endif
    gnt_dest = vc_dest[gnt_vc];
  end

  always_comb begin
    th_mf_d    = (state_q == S_INIT) ? umbral_mf : th_mf_q;
    th_vc_d    = (state_q == S_INIT) ? umbral_vc : th_vc_q;
    mf_wr_d    = mf_push_ok ? mf_wr_q + MFAW'(1) : mf_wr_q;
    mf_rd_d    = mf_pop ? mf_rd_q + MFAW'(1) : mf_rd_q;
    mf_count_d = mf_count_q;
    if (mf_push_ok && !mf_pop)      mf_count_d = mf_count_q + (MFAW+1)'(1);
    else if (!mf_push_ok && mf_pop) mf_count_d = mf_count_q - (MFAW+1)'(1);
    any_busy = (mf_count_q != '0) || (valid_q != 2'b00);
    for (int k = 0; k < NUM_VC; k++) begin
      vc_hit[k]     = mf_pop && (head_vc == VCW'(k));
      vc_pop[k]     = gnt_valid && (gnt_vc == VCW'(k));
      vc_wr[k]      = vc_hit[k] && ((vc_count_q[k] != VC_FULL) || vc_pop[k]);
      vc_err[k]     = vc_hit[k] && (vc_count_q[k] == VC_FULL) && !vc_pop[k];
      vc_wr_d[k]    = vc_wr[k] ? vc_wr_q[k] + VCAW'(1) : vc_wr_q[k];
      vc_rd_d[k]    = vc_pop[k] ? vc_rd_q[k] + VCAW'(1) : vc_rd_q[k];
      vc_count_d[k] = vc_count_q[k];
      if (vc_wr[k] && !vc_pop[k])      vc_count_d[k] = vc_count_q[k] + (VCAW+1)'(1);
      else if (!vc_wr[k] && vc_pop[k]) vc_count_d[k] = vc_count_q[k] - (VCAW+1)'(1);
      if (vc_count_q[k] != '0) any_busy = 1'b1;
    end
    error_id_d = error_id_q | {vc_err, mf_err};
    // Output registers only move in IDLE/ACTIVE; INIT and ERROR hold them
    for (int d = 0; d < 2; d++) begin
      out_d[d]   = out_q[d];
      valid_d[d] = valid_q[d];
      if (run) begin
        if (gnt_valid && (gnt_dest == d[0])) begin
          out_d[d]   = vc_head[gnt_vc];
          valid_d[d] = 1'b1;
        end else if (rdy[d]) begin
          valid_d[d] = 1'b0;
        end
      end
    end
`ifdef ARB_RR_EN
    rr_ptr_d = gnt_valid ? gnt_vc + VCW'(1) : rr_ptr_q;
`endif
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RESET:           state_d = S_INIT;
      S_INIT:            if (!init) state_d = S_IDLE;
      S_IDLE, S_ACTIVE:  state_d = init ? S_INIT : (any_busy ? S_ACTIVE : S_IDLE);
      S_ERROR:           state_d = S_ERROR;
      default:           state_d = S_RESET;
    endcase
    if ((state_q != S_ERROR) && (mf_err || (vc_err != '0))) state_d = S_ERROR;
  end

  always_comb begin
    idle_out   = state_q == S_IDLE;
    active_out = state_q == S_ACTIVE;
    error_out  = state_q == S_ERROR;
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_RESET;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      th_mf_q    <= (MFAW+1)'(MF_TH_DEF);
      th_vc_q    <= (VCAW+1)'(VC_TH_DEF);
      mf_wr_q    <= '0;
      mf_rd_q    <= '0;
      mf_count_q <= '0;
      valid_q    <= '0;
      error_id_q <= '0;
      for (int k = 0; k < NUM_VC; k++) begin
        vc_wr_q[k]    <= '0;
        vc_rd_q[k]    <= '0;
        vc_count_q[k] <= '0;
      end
      for (int d = 0; d < 2; d++) out_q[d] <= '0;
`ifdef ARB_RR_EN
      rr_ptr_q   <= '0;
`endif
    end else begin
      th_mf_q    <= th_mf_d;
      th_vc_q    <= th_vc_d;
      mf_wr_q    <= mf_wr_d;
      mf_rd_q    <= mf_rd_d;
      mf_count_q <= mf_count_d;
      valid_q    <= valid_d;
      error_id_q <= error_id_d;
      for (int k = 0; k < NUM_VC; k++) begin
        vc_wr_q[k]    <= vc_wr_d[k];
        vc_rd_q[k]    <= vc_rd_d[k];
        vc_count_q[k] <= vc_count_d[k];
      end
      for (int d = 0; d < 2; d++) out_q[d] <= out_d[d];
`ifdef ARB_RR_EN
      rr_ptr_q   <= rr_ptr_d;
`endif
    end
  end

  // Storage needs no reset: occupancy counters define validity
  always_ff @(posedge clk) begin
    if (mf_push_ok) mf_mem_q[mf_wr_q] <= data_in;
    for (int k = 0; k < NUM_VC; k++) begin
      if (vc_wr[k]) vc_mem_q[k][vc_wr_q[k]] <= mf_head;
    end
  end

  assign data_out0 = out_q[0];
  assign data_out1 = out_q[1];
  assign valid_0   = valid_q[0];
  assign valid_1   = valid_q[1];
  assign pausa_mf  = mf_count_q >= th_mf_q;
  assign pausa_vc  = vc_pause;
  assign error_id  = error_id_q;

endmodule
`default_nettype wire

// File: tb/tb_pcie_trans_mvc.sv
`default_nettype none
// Bench for pcie_trans_mvc: directed scenarios plus a randomized run scored
// against per-(VC,destination) ordering queues.
module tb_pcie_trans_mvc;
  logic       clk = 1'b0;
  logic       reset, init, push, ready_0, ready_1;
  logic [2:0] umbral_mf;
  logic [4:0] umbral_vc;
  logic [5:0] data_in;
  logic [5:0] data_out0, data_out1;
  logic       valid_0, valid_1, pausa_mf, active_out, idle_out, error_out;
  logic [1:0] pausa_vc;
  logic [2:0] error_id;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pcie_trans_mvc dut (
    .clk(clk), .reset(reset), .init(init), .umbral_mf(umbral_mf), .umbral_vc(umbral_vc),
    .push(push), .data_in(data_in), .ready_0(ready_0), .ready_1(ready_1),
    .data_out0(data_out0), .data_out1(data_out1), .valid_0(valid_0), .valid_1(valid_1),
    .pausa_mf(pausa_mf), .pausa_vc(pausa_vc), .active_out(active_out), .idle_out(idle_out),
    .error_out(error_out), .error_id(error_id)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; init = 1'b1; umbral_mf = 3'd2; umbral_vc = 5'd4;
    push = 1'b0; data_in = '0; ready_0 = 1'b0; ready_1 = 1'b0;
    tick();
    checks++;
    if ({idle_out, active_out, error_out} !== 3'b000) begin
      errors++; $display("FAIL reset_flags: got %b expected 000", {idle_out, active_out, error_out});
    end
    checks++;
    if ({valid_0, valid_1, pausa_mf, pausa_vc} !== 5'b0) begin
      errors++; $display("FAIL reset_outputs: got %b expected 00000", {valid_0, valid_1, pausa_mf, pausa_vc});
    end
    checks++;
    if (error_id !== 3'b000) begin
      errors++; $display("FAIL reset_error_id: got %b expected 000", error_id);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (idle_out !== 1'b0) begin
      errors++; $display("FAIL init_not_idle: got %b expected 0", idle_out);
    end
    init = 1'b0;
    tick();
    checks++;
    if (idle_out !== 1'b1) begin
      errors++; $display("FAIL idle_after_init: got %b expected 1", idle_out);
    end
  endtask

  task automatic test_latency();
    logic exp_v;
    ready_0 = 1'b1; data_in = 6'h05; push = 1'b1;
    tick();
    push = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      exp_v = (c == 3);
      checks++;
      if (valid_0 !== exp_v) begin
        errors++; $display("FAIL latency_valid_c%0d: got %b expected %b", c, valid_0, exp_v);
      end
      if (c == 3) begin
        checks++;
        if (data_out0 !== 6'h05) begin
          errors++; $display("FAIL latency_data: got %h expected 05", data_out0);
        end
        checks++;
        if (active_out !== 1'b1) begin
          errors++; $display("FAIL latency_active: got %b expected 1", active_out);
        end
      end
      if (c == 6) begin
        checks++;
        if (idle_out !== 1'b1) begin
          errors++; $display("FAIL latency_idle_after: got %b expected 1", idle_out);
        end
      end
      tick();
    end
    ready_0 = 1'b0;
  endtask

  task automatic test_vc_pause();
    int got;
    logic [5:0] exp_d;
    ready_0 = 1'b0; ready_1 = 1'b0;
    for (int i = 0; i < 7; i++) begin
      data_in = 6'h30 | 6'(i); push = 1'b1;
      tick();
    end
    push = 1'b0;
    repeat (4) tick();
    checks++;
    if ({pausa_mf, pausa_vc, error_out} !== 4'b1100) begin
      errors++; $display("FAIL vc_pause_flags: got %b expected 1100", {pausa_mf, pausa_vc, error_out});
    end
    checks++;
    if (valid_1 !== 1'b1 || data_out1 !== 6'h30) begin
      errors++; $display("FAIL vc_pause_hold: got %b/%h expected 1/30", valid_1, data_out1);
    end
    ready_1 = 1'b1;
    got = 0;
    for (int cyc = 0; cyc < 40 && got < 7; cyc++) begin
      if (valid_1) begin
        exp_d = 6'h30 | 6'(got);
        checks++;
        if (data_out1 !== exp_d) begin
          errors++; $display("FAIL vc_drain_order%0d: got %h expected %h", got, data_out1, exp_d);
        end
        got++;
      end
      tick();
    end
    checks++;
    if (got != 7) begin
      errors++; $display("FAIL vc_drain_count: got %0d expected 7", got);
    end
    ready_1 = 1'b0;
    repeat (3) tick();
    checks++;
    if ({pausa_mf, pausa_vc, idle_out} !== 4'b0001) begin
      errors++; $display("FAIL vc_drain_idle: got %b expected 0001", {pausa_mf, pausa_vc, idle_out});
    end
  endtask

  task automatic test_arbitration();
    logic [5:0] q0[$], q1[$], exp[$];
    int got;
    ready_0 = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      q0.push_back(6'(i));
      q1.push_back(6'h20 | 6'(i));
    end
    for (int i = 0; i < 3; i++) begin
      data_in = q0[i]; push = 1'b1; tick();
      data_in = q1[i]; push = 1'b1; tick();
    end
    push = 1'b0;
    repeat (8) tick();
`ifdef ARB_RR_EN
    while (q0.size() + q1.size() > 0) begin
      if (q0.size() > 0) exp.push_back(q0.pop_front());
      if (q1.size() > 0) exp.push_back(q1.pop_front());
    end
`else
    exp = {q0, q1};
`endif
    ready_0 = 1'b1;
    got = 0;
    for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
      if (valid_0) begin
        checks++;
        if (data_out0 !== exp[got]) begin
          errors++; $display("FAIL arb_order%0d: got %h expected %h", got, data_out0, exp[got]);
        end
        got++;
      end
      tick();
    end
    checks++;
    if (got != 6) begin
      errors++; $display("FAIL arb_count: got %0d expected 6", got);
    end
    ready_0 = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_mf_error();
    ready_0 = 1'b0; ready_1 = 1'b0;
    for (int i = 0; i < 5; i++) begin data_in = 6'(i); push = 1'b1; tick(); end
    for (int i = 0; i < 5; i++) begin data_in = 6'h30 | 6'(i); push = 1'b1; tick(); end
    push = 1'b0;
    repeat (8) tick();
    for (int i = 0; i < 4; i++) begin data_in = 6'h08 | 6'(i); push = 1'b1; tick(); end
    push = 1'b0;
    repeat (3) tick();
    checks++;
    if ({pausa_mf, pausa_vc, error_out} !== 4'b1110) begin
      errors++; $display("FAIL mf_full_flags: got %b expected 1110", {pausa_mf, pausa_vc, error_out});
    end
    data_in = 6'h3f; push = 1'b1;
    tick();
    push = 1'b0;
    checks++;
    if ({error_out, active_out, idle_out, error_id} !== 6'b100001) begin
      errors++; $display("FAIL mf_overflow: got %b expected 100001", {error_out, active_out, idle_out, error_id});
    end
    ready_0 = 1'b1; ready_1 = 1'b1; push = 1'b1; init = 1'b1;
    repeat (5) tick();
    push = 1'b0; init = 1'b0;
    checks++;
    if ({error_out, error_id, pausa_vc} !== 6'b100111) begin
      errors++; $display("FAIL error_sticky: got %b expected 100111", {error_out, error_id, pausa_vc});
    end
    checks++;
    if ({valid_0, valid_1} !== 2'b11 || data_out0 !== 6'h00 || data_out1 !== 6'h30) begin
      errors++; $display("FAIL error_frozen_out: got %b %h %h expected 11 00 30", {valid_0, valid_1}, data_out0, data_out1);
    end
    ready_0 = 1'b0; ready_1 = 1'b0;
  endtask

  task automatic test_reset_midop();
    reset = 1'b1; tick();
    reset = 1'b0; umbral_mf = 3'd3; umbral_vc = 5'd12;
    tick(); tick();
    checks++;
    if (idle_out !== 1'b1) begin
      errors++; $display("FAIL recover_idle: got %b expected 1", idle_out);
    end
    for (int i = 1; i <= 3; i++) begin data_in = 6'(i); push = 1'b1; tick(); end
    push = 1'b0;
    repeat (2) tick();
    checks++;
    if (active_out !== 1'b1) begin
      errors++; $display("FAIL midop_active: got %b expected 1", active_out);
    end
    reset = 1'b1; tick();
    reset = 1'b0;
    checks++;
    if ({valid_0, valid_1, pausa_mf, pausa_vc, idle_out, active_out, error_out, error_id} !== 11'b0) begin
      errors++; $display("FAIL midop_reset: got %b expected 0", {valid_0, valid_1, pausa_mf, pausa_vc, idle_out, active_out, error_out, error_id});
    end
    tick();
    checks++;
    if ({idle_out, active_out} !== 2'b00) begin
      errors++; $display("FAIL midop_init: got %b expected 00", {idle_out, active_out});
    end
    tick();
    ready_0 = 1'b1; ready_1 = 1'b1;
    for (int c = 0; c < 5; c++) begin
      checks++;
      if ({idle_out, valid_0, valid_1} !== 3'b100) begin
        errors++; $display("FAIL midop_discard_c%0d: got %b expected 100", c, {idle_out, valid_0, valid_1});
      end
      tick();
    end
  endtask

  task automatic test_random();
    logic [5:0] sb[4][$];
    logic [5:0] exp_d, dout[2], hold_d[2];
    logic       vld[2], rdy[2], hold[2];
    int         key, outstanding;
    hold[0] = 1'b0; hold[1] = 1'b0;
    hold_d[0] = '0; hold_d[1] = '0;
    outstanding = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (cyc < 400) begin
        rdy[0] = ($urandom_range(0, 9) < 6);
        rdy[1] = ($urandom_range(0, 9) < 6);
        push = !pausa_mf && ($urandom_range(0, 3) != 0);
      end else begin
        rdy[0] = 1'b1; rdy[1] = 1'b1; push = 1'b0;
      end
      data_in = 6'($urandom);
      ready_0 = rdy[0]; ready_1 = rdy[1];
      vld[0] = valid_0; vld[1] = valid_1;
      dout[0] = data_out0; dout[1] = data_out1;
      for (int d = 0; d < 2; d++) begin
        if (hold[d]) begin
          checks++;
          if (vld[d] !== 1'b1 || dout[d] !== hold_d[d]) begin
            errors++; $display("FAIL rand_hold_d%0d: got %b/%h expected 1/%h", d, vld[d], dout[d], hold_d[d]);
          end
        end
        hold[d] = vld[d] && !rdy[d];
        hold_d[d] = dout[d];
        if (vld[d] && rdy[d]) begin
          key = {dout[d][5], d[0]};
          checks++;
          if (dout[d][4] !== d[0] || sb[key].size() == 0) begin
            errors++; $display("FAIL rand_unexpected_d%0d: got %h expected none", d, dout[d]);
          end else begin
            exp_d = sb[key].pop_front();
            outstanding--;
            if (dout[d] !== exp_d) begin
              errors++; $display("FAIL rand_order_d%0d: got %h expected %h", d, dout[d], exp_d);
            end
          end
        end
      end
      if (push) begin
        sb[{data_in[5], data_in[4]}].push_back(data_in);
        outstanding++;
      end
      tick();
    end
    push = 1'b0;
    checks++;
    if (outstanding != 0) begin
      errors++; $display("FAIL rand_drain: got %0d packets left expected 0", outstanding);
    end
    checks++;
    if ({error_out, error_id} !== 4'b0) begin
      errors++; $display("FAIL rand_no_error: got %b expected 0000", {error_out, error_id});
    end
    ready_0 = 1'b0; ready_1 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_latency();
    test_vc_pause();
    test_arbitration();
    test_mf_error();
    test_reset_midop();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
`default_nettype wire
